// File: rtl/if_fetch_pkg.sv
// Shared CPU constants for the instruction fetch stage: bubble instruction,
// reset PC and the fetch FSM encoding.
package if_fetch_pkg;

  localparam logic [15:0] NOP_INST = 16'h0800;
  localparam logic [17:0] PC_RESET = 18'h08000;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE  = 2'd0;
  localparam fetch_state_t ST_REQ   = 2'd1;
  localparam fetch_state_t ST_WAIT  = 2'd2;
  localparam fetch_state_t ST_FLUSH = 2'd3;

endpackage

// File: rtl/if_fetch_skid.sv
// One-entry skid buffer holding a fetched instruction while decode is stalled.
module if_skid
  import if_fetch_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic              take,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] pc,
  output logic              valid,
  output logic [DATA_W-1:0] q_data,
  output logic [ADDR_W-1:0] q_pc
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_pc;

  // A flush empties the entry even if a load would happen in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= DATA_W'(NOP_INST);
      r_pc    <= ADDR_W'(PC_RESET);
    end else if (clear) begin
      r_valid <= 1'b0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= data;
      r_pc    <= pc;
    end else if (take) begin
      r_valid <= 1'b0;
    end
  end

  assign valid  = r_valid;
  assign q_data = r_data;
  assign q_pc   = r_pc;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: issues single outstanding reads on the shared bus
// and presents instructions to decode with a one-entry skid for stalls.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int                 ADDR_W   = 18,
  parameter int                 DATA_W   = 16,
  parameter logic [DATA_W-1:0]  NOP_INST = DATA_W'(if_fetch_pkg::NOP_INST)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              pc_jump,
  output logic              pc_write,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_busy,
  input  logic              id_stall,
  output logic [DATA_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid
);

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(PC_RESET);

  fetch_state_t      r_state;
  fetch_state_t      w_next_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_inst_pc;
  logic              r_valid;

  logic              w_flush;
  logic              w_issue;
  logic              w_accept;
  logic              w_to_skid;
  logic              w_release;
  logic              w_skid_valid;
  logic [DATA_W-1:0] w_skid_data;
  logic [ADDR_W-1:0] w_skid_pc;

  assign w_flush   = !pc_jump;
  assign w_issue   = (r_state == ST_IDLE) && !mem_busy && pc_jump;
  assign w_accept  = (r_state == ST_REQ) && mem_ack && pc_jump && (!r_valid || !id_stall);
  assign w_to_skid = (r_state == ST_REQ) && mem_ack && pc_jump && r_valid && id_stall;
  assign w_release = (r_state == ST_WAIT) && pc_jump && !id_stall;

  // Combinational outputs are forced to reset values so reset acts before the next edge.
  assign mem_req  = rst && (w_issue || (r_state == ST_REQ) || (r_state == ST_FLUSH));
  assign mem_addr = !rst ? PC_INIT : ((r_state == ST_IDLE) ? pc : r_addr);
  assign pc_write = !rst || !(w_flush || w_accept || w_release);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_issue) w_next_state = ST_REQ;
      end
      ST_REQ: begin
        if (w_flush)      w_next_state = mem_ack ? ST_IDLE : ST_FLUSH;
        else if (mem_ack) w_next_state = w_to_skid ? ST_WAIT : ST_IDLE;
      end
      ST_WAIT: begin
        if (w_flush || !id_stall) w_next_state = ST_IDLE;
      end
      ST_FLUSH: begin
        if (mem_ack) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_addr  <= PC_INIT;
    end else begin
      r_state <= w_next_state;
      if (w_issue) r_addr <= pc;
    end
  end

  // Output slot: flush wins, then new data, then skid drain, then bubble on consume.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inst    <= NOP_INST;
      r_inst_pc <= PC_INIT;
      r_valid   <= 1'b0;
    end else if (w_flush) begin
      r_inst  <= NOP_INST;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_inst    <= mem_rdata;
      r_inst_pc <= r_addr;
      r_valid   <= 1'b1;
    end else if (w_release) begin
      r_inst    <= w_skid_data;
      r_inst_pc <= w_skid_pc;
      r_valid   <= w_skid_valid;
    end else if (!id_stall) begin
      r_inst  <= NOP_INST;
      r_valid <= 1'b0;
    end
  end

  if_skid #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (w_to_skid),
    .clear  (w_flush),
    .take   (w_release),
    .data   (mem_rdata),
    .pc     (r_addr),
    .valid  (w_skid_valid),
    .q_data (w_skid_data),
    .q_pc   (w_skid_pc)
  );

  assign inst_out   = r_inst;
  assign inst_pc    = r_inst_pc;
  assign inst_valid = r_valid;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios plus randomized traffic against a
// transaction-level model of the fetch slot, skid and outstanding request.
module tb_if_fetch;

  localparam logic [15:0] NOP = 16'h0800;
  localparam logic [17:0] PCR = 18'h08000;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] pc;
  logic        pc_jump;
  logic        pc_write;
  logic        mem_req;
  logic [17:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        mem_busy;
  logic        id_stall;
  logic [15:0] inst_out;
  logic [17:0] inst_pc;
  logic        inst_valid;

  int checks = 0;
  int passes = 0;
  logic [15:0] prev_data;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .pc_jump    (pc_jump),
    .pc_write   (pc_write),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .mem_busy   (mem_busy),
    .id_stall   (id_stall),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid)
  );

  task automatic drive(input logic j, input logic b, input logic s, input logic a,
                       input logic [15:0] d, input logic [17:0] p);
    pc_jump = j; mem_busy = b; id_stall = s; mem_ack = a; mem_rdata = d; pc = p;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    drive(1, 0, 0, 0, 16'h0, PCR);
    @(negedge clk); @(negedge clk); #2;
    checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got %0h want 0", mem_req); else passes++;
    checks++; if (mem_addr !== PCR) $display("FAIL reset_mem_addr got %0h want %0h", mem_addr, PCR); else passes++;
    checks++; if (pc_write !== 1'b1) $display("FAIL reset_pc_write got %0h want 1", pc_write); else passes++;
    checks++; if (inst_out !== NOP) $display("FAIL reset_inst_out got %0h want %0h", inst_out, NOP); else passes++;
    checks++; if (inst_pc !== PCR) $display("FAIL reset_inst_pc got %0h want %0h", inst_pc, PCR); else passes++;
    checks++; if (inst_valid !== 1'b0) $display("FAIL reset_inst_valid got %0h want 0", inst_valid); else passes++;
    @(negedge clk);
  endtask

  task automatic test_single_fetch;
    int lows = 0;
    rst = 1'b1;
    drive(1, 0, 0, 0, 16'h0, PCR); #2;
    checks++; if (mem_req !== 1'b1 || mem_addr !== PCR) $display("FAIL fetch_issue got req=%0h addr=%0h want req=1 addr=%0h", mem_req, mem_addr, PCR); else passes++;
    if (!pc_write) lows++;
    @(negedge clk);
    drive(1, 0, 0, 1, 16'h4A01, PCR); #2;
    checks++; if (mem_req !== 1'b1 || mem_addr !== PCR) $display("FAIL fetch_hold_addr got req=%0h addr=%0h want req=1 addr=%0h", mem_req, mem_addr, PCR); else passes++;
    if (!pc_write) lows++;
    @(negedge clk);
    drive(1, 1, 1, 0, 16'h0, 18'h08001); #2;
    checks++; if (inst_out !== 16'h4A01 || inst_pc !== PCR || inst_valid !== 1'b1) $display("FAIL fetch_out got %0h@%0h v=%0h want 4a01@%0h v=1", inst_out, inst_pc, inst_valid, PCR); else passes++;
    if (!pc_write) lows++;
    @(negedge clk); #2;
    if (!pc_write) lows++;
    checks++; if (lows != 1) $display("FAIL fetch_pc_write_pulses got %0d want 1", lows); else passes++;
    @(negedge clk);
  endtask

  task automatic test_mem_busy;
    logic [15:0] r = 16'($urandom);
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 1, 0, 16'h0, 18'h00123); #2;
      checks++; if (mem_req !== 1'b0 || pc_write !== 1'b1) $display("FAIL busy_cycle%0d got req=%0h pcw=%0h want req=0 pcw=1", k, mem_req, pc_write); else passes++;
      @(negedge clk);
    end
    drive(1, 0, 1, 0, 16'h0, 18'h00123); #2;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 18'h00123) $display("FAIL busy_release got req=%0h addr=%0h want req=1 addr=123", mem_req, mem_addr); else passes++;
    @(negedge clk);
    drive(1, 1, 0, 1, r, 18'h00123); #2;
    checks++; if (pc_write !== 1'b0) $display("FAIL busy_ack_pcw got %0h want 0", pc_write); else passes++;
    @(negedge clk);
    drive(1, 1, 1, 0, 16'h0, 18'h00124); #2;
    checks++; if (inst_out !== r || inst_pc !== 18'h00123) $display("FAIL busy_out got %0h@%0h want %0h@123", inst_out, inst_pc, r); else passes++;
    prev_data = r;
    @(negedge clk);
  endtask

  task automatic test_skid;
    drive(1, 0, 1, 0, 16'h0, 18'h01000); #2;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 18'h01000) $display("FAIL skid_issue got req=%0h addr=%0h want req=1 addr=1000", mem_req, mem_addr); else passes++;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 1, 0, 16'h0, 18'h01000); #2;
      checks++; if (mem_addr !== 18'h01000 || inst_out !== prev_data || pc_write !== 1'b1) $display("FAIL skid_stall%0d got addr=%0h out=%0h pcw=%0h want addr=1000 out=%0h pcw=1", k, mem_addr, inst_out, pc_write, prev_data); else passes++;
      @(negedge clk);
    end
    drive(1, 1, 1, 1, 16'h1234, 18'h01000); #2;
    checks++; if (pc_write !== 1'b1) $display("FAIL skid_ack_pcw got %0h want 1", pc_write); else passes++;
    @(negedge clk);
    drive(1, 1, 1, 0, 16'h0, 18'h01000); #2;
    checks++; if (mem_req !== 1'b0 || inst_out !== prev_data || inst_valid !== 1'b1 || pc_write !== 1'b1) $display("FAIL skid_wait got req=%0h out=%0h v=%0h pcw=%0h want req=0 out=%0h v=1 pcw=1", mem_req, inst_out, inst_valid, pc_write, prev_data); else passes++;
    @(negedge clk);
    drive(1, 1, 0, 0, 16'h0, 18'h01000); #2;
    checks++; if (pc_write !== 1'b0) $display("FAIL skid_release_pcw got %0h want 0", pc_write); else passes++;
    @(negedge clk);
    drive(1, 1, 1, 0, 16'h0, 18'h01001); #2;
    checks++; if (inst_out !== 16'h1234 || inst_pc !== 18'h01000 || inst_valid !== 1'b1 || pc_write !== 1'b1) $display("FAIL skid_out got %0h@%0h v=%0h pcw=%0h want 1234@1000 v=1 pcw=1", inst_out, inst_pc, inst_valid, pc_write); else passes++;
    @(negedge clk);
  endtask

  task automatic test_flush_req;
    drive(1, 0, 1, 0, 16'h0, 18'h02000);
    @(negedge clk);
    drive(0, 1, 1, 0, 16'h0, 18'h02000); #2;
    checks++; if (pc_write !== 1'b0) $display("FAIL flreq_pcw got %0h want 0", pc_write); else passes++;
    @(negedge clk);
    drive(1, 1, 1, 0, 16'h0, 18'h03000); #2;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 18'h02000 || pc_write !== 1'b1) $display("FAIL flreq_hold got req=%0h addr=%0h pcw=%0h want req=1 addr=2000 pcw=1", mem_req, mem_addr, pc_write); else passes++;
    checks++; if (inst_valid !== 1'b0 || inst_out !== NOP) $display("FAIL flreq_cleared got %0h v=%0h want %0h v=0", inst_out, inst_valid, NOP); else passes++;
    @(negedge clk);
    drive(1, 1, 0, 1, 16'hDEAD, 18'h03000); #2;
    checks++; if (mem_req !== 1'b1 || pc_write !== 1'b1) $display("FAIL flreq_ack got req=%0h pcw=%0h want req=1 pcw=1", mem_req, pc_write); else passes++;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      drive(1, 1, 0, 0, 16'h0, 18'h03000); #2;
      checks++; if (inst_out !== NOP || inst_valid !== 1'b0) $display("FAIL flreq_drop%0d got %0h v=%0h want %0h v=0", k, inst_out, inst_valid, NOP); else passes++;
      @(negedge clk);
    end
  endtask

  task automatic test_flush_ack;
    drive(1, 0, 0, 0, 16'h0, 18'h03000);
    @(negedge clk);
    drive(0, 1, 0, 1, 16'hBEEF, 18'h03000); #2;
    checks++; if (pc_write !== 1'b0) $display("FAIL flack_pcw got %0h want 0", pc_write); else passes++;
    @(negedge clk);
    drive(1, 0, 0, 0, 16'h0, 18'h03456); #2;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 18'h03456 || inst_valid !== 1'b0 || inst_out !== NOP) $display("FAIL flack_newreq got req=%0h addr=%0h out=%0h v=%0h want req=1 addr=3456 out=%0h v=0", mem_req, mem_addr, inst_out, inst_valid, NOP); else passes++;
    @(negedge clk);
    drive(1, 1, 0, 1, 16'h5678, 18'h03456);
    @(negedge clk);
    drive(1, 1, 1, 0, 16'h0, 18'h03457); #2;
    checks++; if (inst_out !== 16'h5678 || inst_pc !== 18'h03456 || inst_valid !== 1'b1) $display("FAIL flack_out got %0h@%0h v=%0h want 5678@3456 v=1", inst_out, inst_pc, inst_valid); else passes++;
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    drive(1, 0, 1, 0, 16'h0, 18'h04000);
    @(negedge clk);
    drive(1, 1, 1, 0, 16'h0, 18'h04000); #2;
    checks++; if (mem_req !== 1'b1 || inst_valid !== 1'b1) $display("FAIL arst_pre got req=%0h v=%0h want req=1 v=1", mem_req, inst_valid); else passes++;
    #1 rst = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || mem_addr !== PCR || pc_write !== 1'b1) $display("FAIL arst_comb got req=%0h addr=%0h pcw=%0h want req=0 addr=%0h pcw=1", mem_req, mem_addr, pc_write, PCR); else passes++;
    checks++; if (inst_out !== NOP || inst_pc !== PCR || inst_valid !== 1'b0) $display("FAIL arst_regs got %0h@%0h v=%0h want %0h@%0h v=0", inst_out, inst_pc, inst_valid, NOP, PCR); else passes++;
    @(negedge clk);
    rst = 1'b1;
    drive(1, 1, 1, 1, 16'hAAAA, 18'h04000); #2;
    checks++; if (mem_req !== 1'b0 || pc_write !== 1'b1) $display("FAIL arst_stray got req=%0h pcw=%0h want req=0 pcw=1", mem_req, pc_write); else passes++;
    @(negedge clk);
    drive(1, 1, 1, 0, 16'h0, 18'h04000); #2;
    checks++; if (inst_valid !== 1'b0 || inst_out !== NOP) $display("FAIL arst_ignored got %0h v=%0h want %0h v=0", inst_out, inst_valid, NOP); else passes++;
    @(negedge clk);
  endtask

  typedef struct { logic [15:0] d; logic [17:0] a; } slot_t;

  task automatic test_random;
    slot_t       skid_q[$];
    slot_t       slot;
    bit          m_pend, m_disc, m_ov, loaded;
    logic [17:0] m_addr, m_opc;
    logic [15:0] m_od;
    bit          j, b, s, a, waiting, issuing, accept, rel, e_req, e_pw;
    logic [15:0] d;
    logic [17:0] p, e_addr;
    rst = 1'b0;
    drive(1, 1, 0, 0, 16'h0, PCR);
    @(negedge clk);
    rst = 1'b1;
    m_pend = 0; m_disc = 0; m_ov = 0; m_od = NOP; m_opc = PCR; m_addr = PCR;
    for (int i = 0; i < 400; i++) begin
      j = ($urandom_range(0, 9) != 0);
      b = ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 2) == 0);
      a = m_pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      d = 16'($urandom);
      p = 18'($urandom);
      drive(j, b, s, a, d, p); #2;
      waiting = (skid_q.size() != 0);
      issuing = !m_pend && !waiting && !b && j;
      e_req   = m_pend || issuing;
      e_addr  = m_pend ? m_addr : p;
      accept  = m_pend && !m_disc && a && j && (!m_ov || !s);
      rel     = waiting && j && !s;
      e_pw    = !(!j || accept || rel);
      checks++; if (mem_req !== e_req) $display("FAIL rnd%0d_mem_req got %0h want %0h", i, mem_req, e_req); else passes++;
      if (e_req) begin
        checks++; if (mem_addr !== e_addr) $display("FAIL rnd%0d_mem_addr got %0h want %0h", i, mem_addr, e_addr); else passes++;
      end
      checks++; if (pc_write !== e_pw) $display("FAIL rnd%0d_pc_write got %0h want %0h", i, pc_write, e_pw); else passes++;
      checks++; if (inst_valid !== m_ov || inst_out !== m_od) $display("FAIL rnd%0d_inst got %0h v=%0h want %0h v=%0h", i, inst_out, inst_valid, m_od, m_ov); else passes++;
      if (m_ov) begin
        checks++; if (inst_pc !== m_opc) $display("FAIL rnd%0d_inst_pc got %0h want %0h", i, inst_pc, m_opc); else passes++;
      end
      if (!j) begin
        m_ov = 0; m_od = NOP; skid_q.delete();
        if (m_pend && !a) m_disc = 1;
        else begin m_pend = 0; m_disc = 0; end
      end else begin
        loaded = 0;
        if (m_pend && a) begin
          m_pend = 0;
          if (m_disc) m_disc = 0;
          else if (!m_ov || !s) begin m_ov = 1; m_od = d; m_opc = m_addr; loaded = 1; end
          else skid_q.push_back('{d: d, a: m_addr});
        end else if (issuing) begin
          m_pend = 1; m_addr = p;
        end
        if (rel) begin
          slot = skid_q.pop_front();
          m_ov = 1; m_od = slot.d; m_opc = slot.a;
        end else if (!loaded && !s) begin
          m_ov = 0; m_od = NOP;
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 16'h0, PCR);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_fetch();
    test_mem_busy();
    test_skid();
    test_flush_req();
    test_flush_ack();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
